if_stage_unit: RTL

Instruction-fetch stage of the 5-stage RV64 pipeline, directly upstream of decode. It holds the PC register and an internal instruction ROM, and owns the IF/ID pipeline register. It obeys hazard-unit stall controls and MEM-stage branch redirects. It detects invalid fetch addresses and parks the front end in a HALT state until redirected or reset.

---
 rtl/if_stage_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/if_stage_unit.sv
// RV64 instruction-fetch stage: PC register, internal instruction ROM and the IF/ID pipeline register.
// Single-cycle fetch; obeys hazard stalls, redirects from MEM, and parks in HALT on a bad fetch address.
module if_stage_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pc_write,
   input  logic        if_id_write,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic [63:0] PC,
   output logic [63:0] pc_if_id,
   output logic [31:0] instruction_if_id,
   output logic        valid_if_id,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   typedef enum logic {RUN, HALT} state_t;

   logic [31:0] instr_mem [0:IMEM_DEPTH-1];

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] pcid_q, pcid_d;
   logic [31:0] ins_q, ins_d;
   logic        vld_q, vld_d;
   logic [31:0] cnt_q, cnt_d;

   logic [61:0] word_idx;
   logic        addr_bad;
   logic [31:0] fetch_word;

   assign word_idx = pc_q[63:2];
   assign addr_bad = (pc_q[1:0] != 2'b00) || (word_idx >= 62'(IMEM_DEPTH));
   // The index is only trusted when the address has already been range-checked.
   assign fetch_word = addr_bad ? NOP_INSTR : instr_mem[word_idx[AW-1:0]];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pcid_d  = pcid_q;
      ins_d   = ins_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (branch_taken) begin
               pc_d   = branch_target;
               pcid_d = 64'h0;
               ins_d  = NOP_INSTR;
               vld_d  = 1'b0;
            end else if (addr_bad) begin
               // A stalled fault waits until IF/ID is allowed to advance.
               if (if_id_write) begin
                  state_d = HALT;
                  pcid_d  = 64'h0;
                  ins_d   = NOP_INSTR;
                  vld_d   = 1'b0;
               end
            end else begin
               if (pc_write) begin
                  pc_d = pc_q + 64'd4;
               end
               if (if_id_write) begin
                  pcid_d = pc_q;
                  ins_d  = fetch_word;
                  vld_d  = 1'b1;
                  cnt_d  = cnt_q + 32'd1;
               end
            end
         end
         HALT: begin
            pcid_d = 64'h0;
            ins_d  = NOP_INSTR;
            vld_d  = 1'b0;
            if (branch_taken) begin
               pc_d    = branch_target;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         pcid_q  <= 64'h0;
         ins_q   <= NOP_INSTR;
         vld_q   <= 1'b0;
         cnt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pcid_q  <= pcid_d;
         ins_q   <= ins_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

   assign PC                = pc_q;
   assign pc_if_id          = pcid_q;
   assign instruction_if_id = ins_q;
   assign valid_if_id       = vld_q;
   assign halted            = (state_q == HALT);
   assign fetch_count       = cnt_q;

endmodule
